// File: rtl/rv64_pkg.sv
// ---------------------------------------------------------------------------
// rv64_pkg : shared RV64I load encodings and load-queue entry type
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv64_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef struct packed {
      logic [4:0] rd;
      logic [2:0] funct3;
      logic [2:0] off;
   } ld_entry_t;

   // Byte-offset mask that aligns an address down to the access size.
   function automatic logic [2:0] off_mask(input logic [1:0] size_log2);
      return 3'b111 << size_log2;
   endfunction

endpackage

`default_nettype wire

// File: rtl/ld_align.sv
// ---------------------------------------------------------------------------
// ld_align : extracts and sign/zero-extends a load from a raw doubleword
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ld_align #(
   parameter int XLEN = 64
) (
   input  logic [2:0]      funct3,
   input  logic [2:0]      off,
   input  logic [XLEN-1:0] raw,
   output logic [XLEN-1:0] data
);
   import rv64_pkg::*;

   logic [2:0]      aligned_off;
   logic [XLEN-1:0] shifted;
   logic            sext;

   assign aligned_off = off & off_mask(funct3[1:0]);
   assign shifted     = raw >> {aligned_off, 3'b000};
   assign sext        = ~funct3[2];

   always_comb begin
      data = shifted;
      case (funct3[1:0])
         2'd0:    data = {{(XLEN-8){sext & shifted[7]}},   shifted[7:0]};
         2'd1:    data = {{(XLEN-16){sext & shifted[15]}}, shifted[15:0]};
         2'd2:    data = {{(XLEN-32){sext & shifted[31]}}, shifted[31:0]};
         default: data = shifted;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/wb_unit.sv
// ---------------------------------------------------------------------------
// wb_unit : RV64I writeback, merges ALU results with in-order load responses
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module wb_unit #(
   parameter int XLEN      = 64,
   parameter int LDQ_DEPTH = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            alu_valid,
   output logic            alu_ready,
   input  logic [4:0]      alu_rd,
   input  logic [XLEN-1:0] alu_data,
   input  logic            ld_req_valid,
   output logic            ld_req_ready,
   input  logic [4:0]      ld_req_rd,
   input  logic [2:0]      ld_req_funct3,
   input  logic [2:0]      ld_req_off,
   input  logic            mem_rsp_valid,
   input  logic [XLEN-1:0] mem_rsp_data,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic [31:0]     pending_rd,
   output logic            rsp_err
);
   import rv64_pkg::*;

   localparam int PW = $clog2(LDQ_DEPTH);

   ld_entry_t            q [LDQ_DEPTH];
   logic [LDQ_DEPTH-1:0] q_valid;
   logic [PW:0]          wr_ptr;
   logic [PW:0]          rd_ptr;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   ld_entry_t            head;
   logic [XLEN-1:0]      ld_data;

   assign empty        = (wr_ptr == rd_ptr);
   assign full         = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign push         = ld_req_valid && !full;
   assign pop          = mem_rsp_valid && !empty;
   assign ld_req_ready = !full;
   assign alu_ready    = !pop;
   assign head         = q[rd_ptr[PW-1:0]];

   ld_align #(.XLEN(XLEN)) u_align (
      .funct3 (head.funct3),
      .off    (head.off),
      .raw    (mem_rsp_data),
      .data   (ld_data)
   );

   // Storage needs no reset: entries are only observed through q_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         q[wr_ptr[PW-1:0]] <= '{rd: ld_req_rd, funct3: ld_req_funct3, off: ld_req_off};
      end
   end

   // Push and pop never hit the same slot: that would need full or empty.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         q_valid <= '0;
         rsp_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr                   <= wr_ptr + 1'b1;
            q_valid[wr_ptr[PW-1:0]]  <= 1'b1;
         end
         if (pop) begin
            rd_ptr                   <= rd_ptr + 1'b1;
            q_valid[rd_ptr[PW-1:0]]  <= 1'b0;
         end
         if (mem_rsp_valid && empty) begin
            rsp_err <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else if (pop) begin
         rf_we    <= (head.rd != 5'd0);
         rf_waddr <= head.rd;
         rf_wdata <= ld_data;
      end else if (alu_valid) begin
         rf_we    <= (alu_rd != 5'd0);
         rf_waddr <= alu_rd;
         rf_wdata <= alu_data;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   always_comb begin
      pending_rd = '0;
      for (int i = 0; i < LDQ_DEPTH; i++) begin
         if (q_valid[i]) begin
            pending_rd[q[i].rd] = 1'b1;
         end
      end
      pending_rd[0] = 1'b0;
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_unit.sv
// ---------------------------------------------------------------------------
// tb_wb_unit : directed tables, corner sequences and randomized model check
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_wb_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        ld_req_valid;
   logic        ld_req_ready;
   logic [4:0]  ld_req_rd;
   logic [2:0]  ld_req_funct3;
   logic [2:0]  ld_req_off;
   logic        mem_rsp_valid;
   logic [63:0] mem_rsp_data;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [31:0] pending_rd;
   logic        rsp_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   wb_unit #(.XLEN(64), .LDQ_DEPTH(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .ld_req_valid  (ld_req_valid),
      .ld_req_ready  (ld_req_ready),
      .ld_req_rd     (ld_req_rd),
      .ld_req_funct3 (ld_req_funct3),
      .ld_req_off    (ld_req_off),
      .mem_rsp_valid (mem_rsp_valid),
      .mem_rsp_data  (mem_rsp_data),
      .rf_we         (rf_we),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .pending_rd    (pending_rd),
      .rsp_err       (rsp_err)
   );

   typedef struct {
      logic [2:0]  f3;
      logic [2:0]  off;
      logic [63:0] raw;
      logic [63:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0] rd;
      logic [2:0] f3;
      logic [2:0] off;
   } ent_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid     = 1'b0;
      alu_rd        = '0;
      alu_data      = '0;
      ld_req_valid  = 1'b0;
      ld_req_rd     = '0;
      ld_req_funct3 = '0;
      ld_req_off    = '0;
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
   endtask

   task automatic push_load(input logic [4:0] rd, input logic [2:0] f3, input logic [2:0] off);
      ld_req_valid  = 1'b1;
      ld_req_rd     = rd;
      ld_req_funct3 = f3;
      ld_req_off    = off;
      step();
      ld_req_valid  = 1'b0;
   endtask

   // Load result from byte-level arithmetic on the access size.
   function automatic logic [63:0] ref_align(input logic [2:0] f3, input logic [2:0] off,
                                             input logic [63:0] raw);
      int          size;
      int          aoff;
      logic [63:0] mask;
      logic [63:0] v;
      size = 1 << f3[1:0];
      aoff = int'(off) - (int'(off) % size);
      mask = (size == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * size)) - 64'd1);
      v    = (raw >> (8 * aoff)) & mask;
      if (!f3[2] && size != 8 && v[8 * size - 1]) v = v | ~mask;
      return v;
   endfunction

   vec_t tv[9];
   ent_t mq[$];

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [63:0] raw;
      raw = 64'h8899_AABB_CCDD_EEFF;
      tv[0] = '{3'b000, 3'd1, raw, 64'hFFFF_FFFF_FFFF_FFEE};
      tv[1] = '{3'b100, 3'd1, raw, 64'h0000_0000_0000_00EE};
      tv[2] = '{3'b001, 3'd6, raw, 64'hFFFF_FFFF_FFFF_8899};
      tv[3] = '{3'b110, 3'd4, raw, 64'h0000_0000_8899_AABB};
      tv[4] = '{3'b011, 3'd5, raw, 64'h8899_AABB_CCDD_EEFF};
      tv[5] = '{3'b010, 3'd5, raw, 64'hFFFF_FFFF_8899_AABB};
      tv[6] = '{3'b101, 3'd3, raw, 64'h0000_0000_0000_CCDD};
      tv[7] = '{3'b000, 3'd7, raw, 64'hFFFF_FFFF_FFFF_FF88};
      tv[8] = '{3'b010, 3'd0, raw, 64'hFFFF_FFFF_CCDD_EEFF};

      // Reset holds outputs quiet even with an ALU result presented.
      idle_inputs();
      rst       = 1'b0;
      alu_valid = 1'b1;
      alu_rd    = 5'd3;
      alu_data  = 64'h1234_5678_9ABC_DEF0;
      step();
      chk("reset_we", rf_we, 0);
      chk("reset_waddr", rf_waddr, 0);
      chk("reset_wdata", rf_wdata, 0);
      chk("reset_pending", pending_rd, 0);
      chk("reset_err", rsp_err, 0);
      rst = 1'b1;
      step();
      chk("post_reset_we", rf_we, 1);
      chk("post_reset_waddr", rf_waddr, 3);
      chk("post_reset_wdata", rf_wdata, 64'h1234_5678_9ABC_DEF0);
      alu_valid = 1'b0;
      step();
      chk("idle_we", rf_we, 0);
      chk("idle_hold_waddr", rf_waddr, 3);

      // Load alignment table.
      for (int i = 0; i < 9; i++) begin
         push_load(5'(10 + i), tv[i].f3, tv[i].off);
         chk($sformatf("tv%0d_pending", i), pending_rd, 64'd1 << (10 + i));
         mem_rsp_valid = 1'b1;
         mem_rsp_data  = tv[i].raw;
         step();
         mem_rsp_valid = 1'b0;
         chk($sformatf("tv%0d_we", i), rf_we, 1);
         chk($sformatf("tv%0d_waddr", i), rf_waddr, 10 + i);
         chk($sformatf("tv%0d_wdata", i), rf_wdata, tv[i].exp);
      end

      // Collision: load response wins, ALU follows one cycle later.
      push_load(5'd9, 3'b011, 3'd0);
      alu_valid     = 1'b1;
      alu_rd        = 5'd7;
      alu_data      = 64'h0000_0000_0000_0777;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h0000_0000_0000_0999;
      #1;
      chk("coll_alu_ready", alu_ready, 0);
      step();
      mem_rsp_valid = 1'b0;
      chk("coll_first_waddr", rf_waddr, 9);
      chk("coll_first_wdata", rf_wdata, 64'h999);
      #1;
      chk("coll_alu_ready2", alu_ready, 1);
      step();
      alu_valid = 1'b0;
      chk("coll_second_we", rf_we, 1);
      chk("coll_second_waddr", rf_waddr, 7);
      chk("coll_second_wdata", rf_wdata, 64'h777);

      // Queue full and drain in order.
      push_load(5'd1, 3'b011, 3'd0);
      push_load(5'd2, 3'b011, 3'd0);
      push_load(5'd2, 3'b011, 3'd0);
      push_load(5'd4, 3'b011, 3'd0);
      #1;
      chk("full_ready", ld_req_ready, 0);
      chk("full_pending", pending_rd, 32'h16);
      ld_req_valid  = 1'b1;
      ld_req_rd     = 5'd5;
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'hA1;
      #1;
      chk("full_ready_with_pop", ld_req_ready, 0);
      step();
      ld_req_valid = 1'b0;
      chk("drain1_waddr", rf_waddr, 1);
      chk("drain1_wdata", rf_wdata, 64'hA1);
      chk("drain1_pending", pending_rd, 32'h14);
      mem_rsp_data = 64'hA2;
      step();
      chk("drain2_waddr", rf_waddr, 2);
      chk("drain2_pending", pending_rd, 32'h14);
      mem_rsp_data = 64'hA3;
      step();
      chk("drain3_waddr", rf_waddr, 2);
      chk("drain3_wdata", rf_wdata, 64'hA3);
      chk("drain3_pending", pending_rd, 32'h10);
      mem_rsp_data = 64'hA4;
      step();
      mem_rsp_valid = 1'b0;
      chk("drain4_waddr", rf_waddr, 4);
      chk("drain4_we", rf_we, 1);
      chk("drain4_pending", pending_rd, 0);
      chk("drain_no_err", rsp_err, 0);

      // x0 suppression and empty-queue response.
      alu_valid = 1'b1;
      alu_rd    = 5'd0;
      alu_data  = 64'hDEAD_BEEF_DEAD_BEEF;
      step();
      alu_valid = 1'b0;
      chk("x0_we", rf_we, 0);
      chk("x0_waddr", rf_waddr, 0);
      chk("x0_wdata", rf_wdata, 64'hDEAD_BEEF_DEAD_BEEF);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 64'h55;
      step();
      mem_rsp_valid = 1'b0;
      chk("err_set", rsp_err, 1);
      chk("err_no_write", rf_we, 0);
      step();
      step();
      chk("err_sticky", rsp_err, 1);
      rst = 1'b0;
      #1;
      chk("err_cleared_by_reset", rsp_err, 0);
      step();
      rst = 1'b1;

      // Reset with loads in flight.
      step();
      push_load(5'd6, 3'b011, 3'd0);
      push_load(5'd8, 3'b011, 3'd0);
      chk("mid_pending_before", pending_rd, 32'h140);
      rst = 1'b0;
      #1;
      chk("mid_pending_after", pending_rd, 0);
      chk("mid_we", rf_we, 0);
      step();
      rst = 1'b1;
      step();
      mem_rsp_valid = 1'b1;
      step();
      mem_rsp_valid = 1'b0;
      chk("mid_err", rsp_err, 1);
      chk("mid_no_write", rf_we, 0);

      // Randomized run against the queue model.
      begin
         logic [4:0]  last_addr;
         logic [63:0] last_data;
         logic        exp_we;
         logic        exp_err;
         logic        stall_prev;
         logic        pop;
         logic        push;
         logic [31:0] exp_pend;
         ent_t        e;
         idle_inputs();
         rst = 1'b0;
         step();
         rst = 1'b1;
         mq.delete();
         last_addr  = '0;
         last_data  = '0;
         exp_err    = 1'b0;
         stall_prev = 1'b0;
         for (int c = 0; c < 600; c++) begin
            if (!stall_prev) begin
               alu_valid = 1'($urandom_range(0, 1));
               alu_rd    = 5'($urandom_range(0, 31));
               alu_data  = {$urandom, $urandom};
            end
            ld_req_valid  = 1'($urandom_range(0, 1));
            ld_req_rd     = 5'($urandom_range(0, 31));
            ld_req_funct3 = 3'($urandom_range(0, 6));
            ld_req_off    = 3'($urandom_range(0, 7));
            mem_rsp_valid = (mq.size() > 0) ? ($urandom_range(0, 9) < 5)
                                            : ($urandom_range(0, 99) == 0);
            mem_rsp_data  = {$urandom, $urandom};
            #1;
            pop  = mem_rsp_valid && (mq.size() > 0);
            push = ld_req_valid && (mq.size() < 4);
            exp_pend = '0;
            foreach (mq[k]) exp_pend[mq[k].rd] = 1'b1;
            exp_pend[0] = 1'b0;
            chk("rnd_alu_ready", alu_ready, !pop);
            chk("rnd_ld_req_ready", ld_req_ready, mq.size() < 4);
            chk("rnd_pending", pending_rd, exp_pend);
            if (pop) begin
               e         = mq.pop_front();
               exp_we    = (e.rd != 0);
               last_addr = e.rd;
               last_data = ref_align(e.f3, e.off, mem_rsp_data);
            end else if (alu_valid) begin
               exp_we    = (alu_rd != 0);
               last_addr = alu_rd;
               last_data = alu_data;
            end else begin
               exp_we = 1'b0;
            end
            if (mem_rsp_valid && !pop) exp_err = 1'b1;
            if (push) mq.push_back('{ld_req_rd, ld_req_funct3, ld_req_off});
            stall_prev = alu_valid && pop;
            step();
            chk("rnd_we", rf_we, exp_we);
            chk("rnd_waddr", rf_waddr, last_addr);
            chk("rnd_wdata", rf_wdata, last_data);
            chk("rnd_err", rsp_err, exp_err);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
